// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM states and datapath select encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, IMMEX, BRANCH, JUMP, TRAP
    } ctrlState;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
endpackage

// File: rtl/mips_opcode_class.sv
// mips_opcode_class: combinational opcode classifier feeding the controller FSM
module mips_opcode_class
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter bit EXT_IMM_OPS = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                isMem,
    output logic                isLoad,
    output logic                isRtype,
    output logic                isImm,
    output logic                isLogicImm,
    output logic                isBranch,
    output logic                isBne,
    output logic                isJump,
    output logic                illegal
);
    assign isLoad     = opcode == OP_LW;
    assign isMem      = isLoad || opcode == OP_SW;
    assign isRtype    = opcode == OP_RTYPE;
    assign isLogicImm = EXT_IMM_OPS && (opcode == OP_ANDI || opcode == OP_ORI);
    assign isImm      = isLogicImm || opcode == OP_ADDI;
    assign isBne      = opcode == OP_BNE;
    assign isBranch   = isBne || opcode == OP_BEQ;
    assign isJump     = opcode == OP_J;
    assign illegal    = !(isMem || isRtype || isImm || isBranch || isJump);
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore control FSM with memory wait states, trap and retire pulses
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int ALUOP_W       = 2,
    parameter bit MEM_HANDSHAKE = 1,
    parameter bit EXT_IMM_OPS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                memto_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic                illegal_op,
    output logic                instr_done
);
    ctrlState state, nextState;
    logic regDstQ;
    logic [1:0] aluOp;
    logic isMem, isLoad, isRtype, isImm, isLogicImm, isBranch, isBne, isJump, illegal;
    logic ready;

    assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign alu_op = ALUOP_W'(aluOp);

    mips_opcode_class #(.OPCODE_W(OPCODE_W), .EXT_IMM_OPS(EXT_IMM_OPS)) opClass (
        .opcode(opcode), .isMem(isMem), .isLoad(isLoad), .isRtype(isRtype), .isImm(isImm),
        .isLogicImm(isLogicImm), .isBranch(isBranch), .isBne(isBne), .isJump(isJump),
        .illegal(illegal)
    );

    always_ff @(posedge clk) begin
        state   <= rst ? FETCH : nextState;
        regDstQ <= rst ? 1'b0 : state == RTYPEEX ? 1'b1 : state == IMMEX ? 1'b0 : regDstQ;
    end

    // Outputs stay at zero while rst is high, so no strobe can leak out mid-reset.
    always_comb begin
        nextState  = state;
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        aluOp      = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = ready;
                    pc_write  = ready;
                    nextState = ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = SRCB_IMMSH;
                    nextState = illegal ? TRAP : isMem ? MEMADR : isRtype ? RTYPEEX :
                                isImm ? IMMEX : isBranch ? BRANCH : isJump ? JUMP : TRAP;
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    nextState = isLoad ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    nextState = ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    memto_reg  = 1'b1;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
                MEMWR: begin
                    mem_req    = 1'b1;
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = ready;
                    nextState  = ready ? FETCH : MEMWR;
                end
                RTYPEEX: begin
                    alu_src_a = 1'b1;
                    aluOp     = ALUOP_FUNCT;
                    nextState = ALUWB;
                end
                IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    aluOp     = isLogicImm ? ALUOP_LOGIC : ALUOP_ADD;
                    nextState = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = regDstQ;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    aluOp      = ALUOP_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    branch     = !isBne;
                    branch_ne  = isBne;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
                JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
                TRAP: begin
                    illegal_op = 1'b1;
                    nextState  = FETCH;
                end
                default: nextState = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed per-cycle vectors checked through a scoreboard queue
module tb_mips_multicycle_controller;
    typedef struct packed {
        logic       memReq, iord, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
        logic [1:0] aluSrcB, aluOp, pcSrc;
        logic       pcWrite, branch, branchNe, illegalOp, instrDone;
    } outs_t;

    typedef struct {
        string nm;
        outs_t e1;
        outs_t e2;
    } item_t;

    localparam outs_t ZERO      = '0;
    localparam outs_t FET_WAIT  = '{memReq: 1, aluSrcB: 2'b01, default: 0};
    localparam outs_t FET_RDY   = '{memReq: 1, irWrite: 1, pcWrite: 1, aluSrcB: 2'b01, default: 0};
    localparam outs_t DEC       = '{aluSrcB: 2'b11, default: 0};
    localparam outs_t MEMADR    = '{aluSrcA: 1, aluSrcB: 2'b10, default: 0};
    localparam outs_t MEMRD     = '{memReq: 1, iord: 1, default: 0};
    localparam outs_t MEMWB     = '{regWrite: 1, memtoReg: 1, instrDone: 1, default: 0};
    localparam outs_t MEMWR_W   = '{memReq: 1, iord: 1, memWrite: 1, default: 0};
    localparam outs_t MEMWR_R   = '{memReq: 1, iord: 1, memWrite: 1, instrDone: 1, default: 0};
    localparam outs_t REX       = '{aluSrcA: 1, aluOp: 2'b10, default: 0};
    localparam outs_t WB_R      = '{regWrite: 1, regDst: 1, instrDone: 1, default: 0};
    localparam outs_t WB_I      = '{regWrite: 1, instrDone: 1, default: 0};
    localparam outs_t IEX_ADD   = '{aluSrcA: 1, aluSrcB: 2'b10, default: 0};
    localparam outs_t IEX_LOG   = '{aluSrcA: 1, aluSrcB: 2'b10, aluOp: 2'b11, default: 0};
    localparam outs_t BEQ       = '{aluSrcA: 1, aluOp: 2'b01, pcSrc: 2'b01, branch: 1, instrDone: 1, default: 0};
    localparam outs_t BNE       = '{aluSrcA: 1, aluOp: 2'b01, pcSrc: 2'b01, branchNe: 1, instrDone: 1, default: 0};
    localparam outs_t JMP       = '{pcSrc: 2'b10, pcWrite: 1, instrDone: 1, default: 0};
    localparam outs_t TRP       = '{illegalOp: 1, default: 0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
    localparam logic [5:0] ORI = 6'b001101, BQ = 6'b000100, BN = 6'b000101, J = 6'b000010, BAD = 6'b111111;

    logic clk = 0, rst = 1, mem_ready = 0;
    logic [5:0] opcode = '0;
    logic mem_req, iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic pc_write, branch, branch_ne, illegal_op, instr_done;
    logic mem_req2, iord2, mem_write2, ir_write2, reg_dst2, memto_reg2, reg_write2, alu_src_a2;
    logic [1:0] alu_src_b2, alu_op2, pc_src2;
    logic pc_write2, branch2, branch_ne2, illegal_op2, instr_done2;

    item_t q[$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_write(pc_write),
        .branch(branch), .branch_ne(branch_ne), .illegal_op(illegal_op), .instr_done(instr_done)
    );

    mips_multicycle_controller #(.EXT_IMM_OPS(0)) dutNoExt (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req2), .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2),
        .reg_dst(reg_dst2), .memto_reg(memto_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .pc_src(pc_src2), .pc_write(pc_write2),
        .branch(branch2), .branch_ne(branch_ne2), .illegal_op(illegal_op2), .instr_done(instr_done2)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t t;
            outs_t a1, a2;
            t  = q.pop_front();
            a1 = {mem_req, iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, pc_write, branch, branch_ne, illegal_op, instr_done};
            a2 = {mem_req2, iord2, mem_write2, ir_write2, reg_dst2, memto_reg2, reg_write2, alu_src_a2,
                  alu_src_b2, alu_op2, pc_src2, pc_write2, branch2, branch_ne2, illegal_op2, instr_done2};
            vectors += 2;
            if (a1 !== t.e1) begin
                miscompares++;
                $display("FAIL %s ext: got %h want %h", t.nm, a1, t.e1);
            end
            if (a2 !== t.e2) begin
                miscompares++;
                $display("FAIL %s noext: got %h want %h", t.nm, a2, t.e2);
            end
        end
    end

    task automatic step2(input logic r, input logic [5:0] op, input logic rdy,
                         input outs_t e1, input outs_t e2, input string nm);
        item_t t;
        rst = r;
        opcode = op;
        mem_ready = rdy;
        t.nm = nm;
        t.e1 = e1;
        t.e2 = e2;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input outs_t e, input string nm);
        step2(r, op, rdy, e, e, nm);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1, SW, 0, ZERO, "rst_initial");
        step(0, SW, 1, FET_RDY, "sw0_fetch");
        step(0, SW, 1, DEC, "sw0_decode");
        step(0, SW, 1, MEMADR, "sw0_memadr");
        step(0, SW, 0, MEMWR_W, "sw0_memwr_wait");
        step(1, SW, 0, ZERO, "rst_mid_memwr_a");
        step(1, SW, 0, ZERO, "rst_mid_memwr_b");
        step(0, SW, 0, FET_WAIT, "post_rst_fetch_wait");
        step(0, LW, 1, FET_RDY, "lw_fetch");
        step(0, LW, 1, DEC, "lw_decode");
        step(0, LW, 1, MEMADR, "lw_memadr");
        step(0, LW, 1, MEMRD, "lw_memrd");
        step(0, LW, 1, MEMWB, "lw_memwb");
        step(0, SW, 1, FET_RDY, "sw_fetch");
        step(0, SW, 1, DEC, "sw_decode");
        step(0, SW, 1, MEMADR, "sw_memadr");
        for (int i = 0; i < 3; i++) step(0, SW, 0, MEMWR_W, "sw_memwr_wait");
        step(0, SW, 1, MEMWR_R, "sw_memwr_ready");
        step(0, RT, 1, FET_RDY, "r_fetch");
        step(0, RT, 1, DEC, "r_decode");
        step(0, RT, 1, REX, "r_ex");
        step(0, RT, 1, WB_R, "r_wb");
        step(0, ADDI, 1, FET_RDY, "addi_fetch");
        step(0, ADDI, 1, DEC, "addi_decode");
        step(0, ADDI, 1, IEX_ADD, "addi_ex");
        step(0, ADDI, 1, WB_I, "addi_wb");
        step(0, BQ, 1, FET_RDY, "beq_fetch");
        step(0, BQ, 1, DEC, "beq_decode");
        step(0, BQ, 1, BEQ, "beq_branch");
        step(0, BN, 1, FET_RDY, "bne_fetch");
        step(0, BN, 1, DEC, "bne_decode");
        step(0, BN, 1, BNE, "bne_branch");
        step(0, J, 1, FET_RDY, "j_fetch");
        step(0, J, 1, DEC, "j_decode");
        step(0, J, 1, JMP, "j_jump");
        step(0, BAD, 1, FET_RDY, "bad_fetch");
        step(0, BAD, 1, DEC, "bad_decode");
        step(0, BAD, 1, TRP, "bad_trap");
        step(0, LW, 0, FET_WAIT, "lw2_fetch_wait");
        step(0, LW, 1, FET_RDY, "lw2_fetch");
        step(0, LW, 1, DEC, "lw2_decode");
        step(0, LW, 1, MEMADR, "lw2_memadr");
        step(0, LW, 0, MEMRD, "lw2_memrd_wait");
        step(0, LW, 1, MEMRD, "lw2_memrd_ready");
        step(0, LW, 1, MEMWB, "lw2_memwb");
        step(0, RT, 1, FET_RDY, "r2_fetch");
        step(0, RT, 1, DEC, "r2_decode");
        step(0, RT, 1, REX, "r2_ex");
        step(0, RT, 1, WB_R, "r2_wb");
        step(0, ORI, 1, FET_RDY, "ori_fetch");
        step(0, ORI, 1, DEC, "ori_decode");
        step2(0, ORI, 1, IEX_LOG, TRP, "ori_ex_or_trap");
        step2(0, ORI, 1, WB_I, FET_RDY, "ori_wb_or_refetch");
        step(1, ORI, 1, ZERO, "resync_rst");
        step(0, J, 1, FET_RDY, "final_fetch");
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath; the successor to the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-state datapath enables.
- Adds a memory ready/request handshake (wait states), bne/andi/ori decoding, an illegal-opcode trap pulse and an instruction-retire pulse.
- Sits between the instruction register opcode field and the shared datapath; the ALU decoder stays separate and consumes alu_op.

Parameters:
- OPCODE_W, 6: opcode field width.
- ALUOP_W, 2: width of alu_op to the ALU decoder.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is treated as constant 1.
- EXT_IMM_OPS, 1: 1 = andi/ori decoded; 0 = they trap as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  instr[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access requested
- iord  out  1  address source: 0 = PC, 1 = ALUOut
- mem_write  out  1  store strobe (qualified by mem_req)
- ir_write  out  1  latch the instruction register
- reg_dst  out  1  1 = rd, 0 = rt
- memto_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct, 11 = logical-immediate (funct field ignored)
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_write  out  1  unconditional PC write
- branch  out  1  beq qualifier
- branch_ne  out  1  bne qualifier
- illegal_op  out  1  one-cycle trap pulse
- instr_done  out  1  one-cycle retire pulse

Behaviour:
- Opcodes: lw 100011, sw 101011, R-type 000000, addi 001000, andi 001100, ori 001101, beq 000100, bne 000101, j 000010. All others are illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, IMMEX, BRANCH, JUMP, TRAP. Registered state; Moore outputs. Any output not listed for a state is 0.
- rst while rst=1 (including mid-instruction): state becomes FETCH on the next edge. Every output is forced to 0 while rst is high. No memory write may occur during reset.
- FETCH: mem_req=1, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write assert only in a cycle where mem_ready=1, and the state then moves to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: alu_src_b=11, alu_op=00 (branch target computed into ALUOut). Next state:
  - lw/sw: MEMADR
  - R-type: RTYPEEX
  - addi/andi/ori: IMMEX
  - beq/bne: BRANCH
  - j: JUMP
  - otherwise: TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, memto_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. Holds until mem_ready. On the ready cycle it asserts instr_done=1 and moves to FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB with reg_dst=1.
- IMMEX: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for andi/ori. Next state ALUWB with reg_dst=0.
- ALUWB: reg_write=1, memto_reg=0, reg_dst as selected, instr_done=1. Next state FETCH. The reg_dst selection is held in a 1-bit register captured on leaving the EX state.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. branch=1 for beq, branch_ne=1 for bne. instr_done=1. Next state FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Next state FETCH.
- TRAP: illegal_op=1 for exactly one cycle, no writes, instr_done=0. Next state FETCH.
- Latency with mem_ready tied high:
  - lw: 5 cycles
  - sw, R-type, addi/andi/ori: 4 cycles
  - beq/bne, j: 3 cycles
  - illegal: 3 cycles
- Each wait cycle in FETCH/MEMRD/MEMWR adds exactly 1 cycle.
- reg_write, mem_write, pc_write and ir_write are never asserted in the same cycle as illegal_op.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_J)
  - the state enum typedef
  - ALUOP_* and PCSRC_*/SRCB_* encodings
- One natural sub-module: mips_opcode_class, a combinational opcode to {is_mem, is_load, is_rtype, is_imm, is_logic_imm, is_branch, is_bne, is_jump, illegal} classifier, honouring EXT_IMM_OPS.

Test Plan:
- Reset: assert rst for 2 cycles mid-MEMWR with mem_ready=0 -> all outputs 0 during reset, state FETCH after release, no mem_write pulse.
- lw with mem_ready=1: opcode 100011 -> ir_write at cycle 0, MEMRD at cycle 3, reg_write & memto_reg at cycle 4, instr_done at cycle 4 only.
- Wait states: sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, instr_done once, FETCH follows.
- R-type vs ori: 000000 -> alu_op=10, reg_dst=1 in ALUWB. 001101 -> alu_op=11, reg_dst=0. With EXT_IMM_OPS=0, 001101 -> illegal_op pulse.
- Branches: 000100 -> branch=1, branch_ne=0, pc_src=01 in cycle 2. 000101 -> branch_ne=1, branch=0.
- Illegal and jump: 111111 -> illegal_op one cycle, no reg_write/mem_write, back to FETCH. 000010 -> pc_write & pc_src=10 in cycle 2.
